// File: rtl/fft_peak_detect.sv
// Peak-bin detector for the 16-point FFT output stream.
// Takes two beats of eight complex bins per frame and reports the strongest bin once per frame.
module fft_peak_detect #(
  parameter int unsigned DW    = 16,
  parameter int unsigned MAG_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [2*DW-1:0]   fft_d0,
  input  logic [2*DW-1:0]   fft_d1,
  input  logic [2*DW-1:0]   fft_d2,
  input  logic [2*DW-1:0]   fft_d3,
  input  logic [2*DW-1:0]   fft_d4,
  input  logic [2*DW-1:0]   fft_d5,
  input  logic [2*DW-1:0]   fft_d6,
  input  logic [2*DW-1:0]   fft_d7,
  output logic              done,
  output logic [3:0]        freq,
  output logic [MAG_W-1:0]  peak_mag
);

  logic [2*DW-1:0] beat [8];

  assign beat[0] = fft_d0;
  assign beat[1] = fft_d1;
  assign beat[2] = fft_d2;
  assign beat[3] = fft_d3;
  assign beat[4] = fft_d4;
  assign beat[5] = fft_d5;
  assign beat[6] = fft_d6;
  assign beat[7] = fft_d7;

  // Stage 1: squared magnitudes. Components are sign-extended so the products are exact.
  logic signed [MAG_W-1:0] re_x  [8];
  logic signed [MAG_W-1:0] im_x  [8];
  logic        [MAG_W-1:0] mag_d [8];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      re_x[k]  = $signed({{(MAG_W-DW){beat[k][2*DW-1]}}, beat[k][2*DW-1:DW]});
      im_x[k]  = $signed({{(MAG_W-DW){beat[k][DW-1]}}, beat[k][DW-1:0]});
      mag_d[k] = $unsigned(re_x[k] * re_x[k]) + $unsigned(im_x[k] * im_x[k]);
    end
  end

  logic             phase_q;
  logic             s1_valid_q;
  logic             s1_phase_q;
  logic [MAG_W-1:0] s1_mag_q [8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_phase_q <= 1'b0;
      for (int k = 0; k < 8; k++) s1_mag_q[k] <= '0;
    end else begin
      s1_valid_q <= fft_valid;
      if (fft_valid) begin
        phase_q    <= ~phase_q;
        s1_phase_q <= phase_q;
        for (int k = 0; k < 8; k++) s1_mag_q[k] <= mag_d[k];
      end
    end
  end

  // Stage 2: local maximum; strict compare keeps the lower index on ties.
  logic [MAG_W-1:0] loc_max;
  logic [2:0]       loc_idx;

  always_comb begin
    loc_max = s1_mag_q[0];
    loc_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (s1_mag_q[k] > loc_max) begin
        loc_max = s1_mag_q[k];
        loc_idx = 3'(k);
      end
    end
  end

  logic             s2_valid_q;
  logic             s2_phase_q;
  logic [MAG_W-1:0] s2_max_q;
  logic [2:0]       s2_idx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_phase_q <= 1'b0;
      s2_max_q   <= '0;
      s2_idx_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_phase_q <= s1_phase_q;
        s2_max_q   <= loc_max;
        s2_idx_q   <= loc_idx;
      end
    end
  end

  // Stage 3 merges into the running best; the output stage reads the pre-merge best,
  // so a new frame's first beat never disturbs the previous frame's result.
  logic [MAG_W-1:0] best_mag_q;
  logic [3:0]       best_idx_q;
  logic             fin_q;
  logic             done_q;
  logic [3:0]       freq_q;
  logic [MAG_W-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      best_mag_q <= '0;
      best_idx_q <= '0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= '0;
      peak_q     <= '0;
    end else begin
      fin_q  <= s2_valid_q & s2_phase_q;
      done_q <= fin_q;
      if (s2_valid_q) begin
        if (!s2_phase_q) begin
          best_mag_q <= s2_max_q;
          best_idx_q <= {1'b0, s2_idx_q};
        end else if (s2_max_q > best_mag_q) begin
          best_mag_q <= s2_max_q;
          best_idx_q <= {1'b1, s2_idx_q};
        end
      end
      if (fin_q) begin
        freq_q <= best_idx_q;
        peak_q <= best_mag_q;
      end
    end
  end

  assign done     = done_q;
  assign freq     = freq_q;
  assign peak_mag = peak_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: directed frames plus random frames checked every cycle
// against a frame-level argmax model with expected done timing.
module tb_fft_peak_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic [31:0] d [8];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_mag;

  fft_peak_detect #(.DW(16), .MAG_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .fft_valid(fft_valid),
    .fft_d0   (d[0]),
    .fft_d1   (d[1]),
    .fft_d2   (d[2]),
    .fft_d3   (d[3]),
    .fft_d4   (d[4]),
    .fft_d5   (d[5]),
    .fft_d6   (d[6]),
    .fft_d7   (d[7]),
    .done     (done),
    .freq     (freq),
    .peak_mag (peak_mag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [3:0]  f;
    logic [31:0] m;
  } ev_t;

  ev_t         q [$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] frame [16];
  longint      m_mag [16];
  bit          m_phase = 1'b0;
  logic [3:0]  exp_freq = '0;
  logic [31:0] exp_mag = '0;
  logic        exp_done;
  int          pk [4];

  function automatic longint bin_mag(input logic [31:0] w);
    int re;
    int im;
    re = int'($signed(w[31:16]));
    im = int'($signed(w[15:0]));
    return longint'(re) * re + longint'(im) * im;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: model the edge, then compare all outputs 1 time unit later.
  task automatic step();
    int   e = cyc + 1;
    int   bi;
    ev_t  ev;
    if (!rst) begin
      q.delete();
      m_phase  = 1'b0;
      exp_freq = '0;
      exp_mag  = '0;
    end else if (fft_valid) begin
      for (int k = 0; k < 8; k++) m_mag[m_phase ? 8 + k : k] = bin_mag(d[k]);
      if (m_phase) begin
        bi = 0;
        for (int b = 1; b < 16; b++) if (m_mag[b] > m_mag[bi]) bi = b;
        ev.at = e + 3;
        ev.f  = 4'(bi);
        ev.m  = m_mag[bi][31:0];
        q.push_back(ev);
      end
      m_phase = !m_phase;
    end
    @(posedge clk);
    cyc = e;
    #1;
    exp_done = (q.size() > 0 && q[0].at == cyc);
    if (exp_done) begin
      exp_freq = q[0].f;
      exp_mag  = q[0].m;
      void'(q.pop_front());
    end
    check("done", {31'b0, done}, {31'b0, exp_done});
    check("freq", {28'b0, freq}, {28'b0, exp_freq});
    check("peak_mag", peak_mag, exp_mag);
  endtask

  task automatic idle(input int n);
    fft_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) d[k] = $urandom;
      step();
    end
  endtask

  task automatic beat(input int half);
    fft_valid = 1'b1;
    for (int k = 0; k < 8; k++) d[k] = frame[half * 8 + k];
    step();
    fft_valid = 1'b0;
  endtask

  task automatic send(input int gap);
    beat(0);
    idle(gap);
    beat(1);
  endtask

  task automatic fill(input logic [31:0] v);
    for (int b = 0; b < 16; b++) frame[b] = v;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) d[k] = '0;
    rst = 1'b0;
    idle(2);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_freq", {28'b0, freq}, 32'd0);
    check("rst_mag", peak_mag, 32'd0);
    rst = 1'b1;
    idle(1);

    fill('0); frame[5] = 32'h0100_0000;
    send(0); idle(5);
    check("single_freq", {28'b0, freq}, 32'd5);
    check("single_mag", peak_mag, 32'h0001_0000);

    fill(32'h0010_0010); frame[13] = 32'hFF00_0080;
    send(1); idle(5);
    check("beat2_freq", {28'b0, freq}, 32'd13);
    check("beat2_mag", peak_mag, 32'h0001_4000);

    fill('0); frame[2] = 32'h0040_0040; frame[9] = 32'h0040_0040;
    send(0); idle(5);
    check("tie_xbeat_freq", {28'b0, freq}, 32'd2);
    check("tie_xbeat_mag", peak_mag, 32'h0000_2000);

    fill('0); frame[3] = 32'h0040_0040; frame[6] = 32'h0040_0040;
    send(2); idle(5);
    check("tie_local_freq", {28'b0, freq}, 32'd3);

    fill('0); frame[7] = 32'h8000_8000;
    send(0); idle(5);
    check("extreme_freq", {28'b0, freq}, 32'd7);
    check("extreme_mag", peak_mag, 32'h8000_0000);

    fill('0);
    send(0); idle(5);
    check("zero_freq", {28'b0, freq}, 32'd0);
    check("zero_mag", peak_mag, 32'd0);

    // Streaming: back-to-back, then with 3-cycle gaps.
    pk = '{0, 15, 8, 1};
    for (int f = 0; f < 4; f++) begin
      fill(32'h0001_0001); frame[pk[f]] = 32'h0100_0100;
      beat(0);
      beat(1);
    end
    idle(5);
    check("stream_last_freq", {28'b0, freq}, 32'd1);
    for (int f = 0; f < 4; f++) begin
      fill(32'h0001_0001); frame[pk[f]] = 32'h0100_0100;
      beat(0); idle(3);
      beat(1); idle(3);
    end
    idle(3);
    check("gap_last_freq", {28'b0, freq}, 32'd1);

    // Reset after the first beat: no done, outputs cleared, phase restarts.
    fill('0); frame[4] = 32'h0300_0000;
    beat(0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(4);
    check("midrst_mag", peak_mag, 32'd0);
    fill('0); frame[10] = 32'h0200_0000;
    send(0); idle(5);
    check("midrst_freq", {28'b0, freq}, 32'd10);
    check("midrst_mag2", peak_mag, 32'h0004_0000);

    // Random frames, with small values mixed in to provoke ties.
    for (int r = 0; r < 30; r++) begin
      for (int b = 0; b < 16; b++)
        frame[b] = ($urandom_range(0, 1) == 1) ? 32'($urandom) :
                   {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
      send($urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Sits directly downstream of the 16-point fft block and consumes its output.
- Each 16-bin spectrum arrives as two beats of eight complex bins on fft_d0..fft_d7, qualified by fft_valid.
- The block computes the squared magnitude of every bin and reports, once per frame, the index and magnitude of the strongest bin.
- Fully pipelined: accepts one beat per clock indefinitely.

Parameters:
- DW, 16, width of each real/imag component (signed two's complement).
- MAG_W, 32, width of squared magnitude (= 2*DW).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low: rst=0 at a rising edge of clk resets the block.
- fft_valid  input  1  the eight bins on fft_d0..fft_d7 are valid this cycle.
- fft_d0..fft_d7  input  32 each  bin data: [31:16] real, [15:0] imag, signed.
- done  output  1  one-cycle pulse; freq/peak_mag updated.
- freq  output  4  index (0..15) of the peak bin of the last completed frame.
- peak_mag  output  32  re^2+im^2 of that bin, unsigned.

Behaviour:
- Reset (rst=0 at a clk edge):
  - done=0, freq=0, peak_mag=0.
  - Beat phase=0, all pipeline valid bits=0, running best cleared.
  - A partial frame in flight is discarded and produces no done.
- Framing:
  - Phase bit selects the bin offset. Phase 0 beat: fft_dk is bin k. Phase 1 beat: fft_dk is bin 8+k.
  - Phase toggles on every sampled fft_valid=1 and holds while fft_valid=0.
  - Gaps of any length between beats or between frames are legal.
  - fft_d* are ignored (may be X) when fft_valid=0.
- Stage 1 (edge E, beat sampled):
  - Register mag_k = re_k*re_k + im_k*im_k for k=0..7.
  - Signed 16x16 products; sum unsigned 32-bit.
  - Maximum value is 0x80000000 (re=im=-32768). No overflow possible; no saturation.
  - Register the phase and a valid bit alongside.
- Stage 2 (edge E+1):
  - 8-to-1 compare tree yields local max value and local 3-bit index.
  - Strict greater-than compare: on ties the lower index wins.
- Stage 3 (edge E+2), merge with running best:
  - Phase 0 beat: best <= {local value, index {0,local}}.
  - Phase 1 beat: if local value > best value, best <= {local value, index {1,local}}; otherwise keep best. Ties keep the phase-0 bin.
- Output (edge E+3, for a phase-1 beat sampled at E):
  - freq and peak_mag load the final best; done=1 for exactly one cycle.
- freq and peak_mag hold until the next done.
- Latency: done is visible 3 cycles after the edge sampling the second beat.
- Throughput: back-to-back frames (fft_valid continuously 1) give one done every 2 cycles. No stalls, no backpressure.
- Simultaneous events: the stage-3 merge for frame N's phase-0 beat and the output update for frame N-1 on the same edge are independent. Frame N-1's result must not be corrupted.
- All-zero frame: freq=0, peak_mag=0, done still pulses.

Test Plan:
- Single frame, bin 5 = (0x0100, 0x0000), all other bins 0 -> done one cycle, 3 cycles after beat 2; freq=5, peak_mag=0x00010000.
- Peak in second beat: bin 13 = (0xFF00, 0x0080), others 0x00100010 -> freq=13, peak_mag=0x00014000.
- Tie: bins 2 and 9 both (0x0040, 0x0040), others 0 -> freq=2, peak_mag=0x00002000. Repeat with the tie at bins 3 and 6 -> freq=3.
- Extreme value: bin 7 = (0x8000, 0x8000) -> peak_mag=0x80000000, freq=7, no wrap.
- Streaming: four frames with fft_valid held high (8 cycles), peaks at bins 0, 15, 8, 1 -> four done pulses 2 cycles apart, freq 0, 15, 8, 1 in order. Repeat with 3-cycle gaps between beats -> same results, correct pulse timing.
- Reset mid-frame: rst=0 for one cycle after the first beat of a frame -> no done. The next full frame (peak bin 10) -> freq=10, proving phase restarted at 0.
